// File: rtl/ps2_host_tx_if.sv
// Command/status and pad-level signals between a PS/2 host transmitter and its user.
// The slave modport is the transmitter side; the master modport is the user/pad side.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_start,
        output ps2_clk_in,
        output ps2_dat_in,
        input  ps2_clk_oe,
        input  ps2_dat_oe,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        input  ps2_clk_in,
        input  ps2_dat_in,
        output ps2_clk_oe,
        output ps2_dat_oe,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, then data, odd parity
// and stop shifted out on device clock falling edges, followed by an ACK check.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned REQ_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input logic          clk,
    input logic          reset,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] ReqLast = CntW'(REQ_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StAck,
        StRelease
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [TmoW-1:0] tmo_q;
    logic [3:0]      bit_idx_q;
    logic [8:0]      shift_q;
    logic            clk_oe_q;
    logic            dat_oe_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic clk_fall;
    logic tmo_hit;

    // Synchronizers reset to the idle (released, pulled-up) level so no edge is seen after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= bus.ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= bus.ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q;
    assign tmo_hit  = (state_q inside {StData, StAck, StRelease}) && (tmo_q == TmoLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tmo_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            // Timeout wins over any edge seen in the same cycle.
            if (tmo_hit) begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                error_q  <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.tx_start) begin
                            shift_q  <= {~^bus.tx_data, bus.tx_data};
                            cnt_q    <= '0;
                            clk_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == InhLast) begin
                            cnt_q    <= '0;
                            dat_oe_q <= 1'b1;
                            state_q  <= StReq;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StReq: begin
                        if (cnt_q == ReqLast) begin
                            cnt_q     <= '0;
                            clk_oe_q  <= 1'b0;
                            bit_idx_q <= '0;
                            tmo_q     <= '0;
                            state_q   <= StData;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (clk_fall) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            // Edges 1..9 present data LSB-first then parity; edge 10 is the stop bit.
                            if (bit_idx_q == 4'd9) begin
                                dat_oe_q <= 1'b0;
                                state_q  <= StAck;
                            end else begin
                                dat_oe_q <= ~shift_q[0];
                                shift_q  <= shift_q >> 1;
                            end
                        end
                    end
                    StAck: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (clk_fall) begin
                            if (!dat_sync_q) begin
                                state_q <= StRelease;
                            end else begin
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StRelease: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (clk_sync_q && dat_sync_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain pad model plus a behavioural PS/2 device
// that clocks the frame, samples each bit and optionally ACKs.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 60;
    localparam int unsigned REQ  = 10;
    localparam int unsigned TMO  = 2000;
    localparam int          HALF = 20;

    logic clk = 1'b0;
    logic reset;
    logic dev_clk;
    logic dev_dat;

    int vectors     = 0;
    int miscompares = 0;
    int done_n      = 0;
    int err_n       = 0;
    int both_n      = 0;
    int sync_bad    = 0;
    logic busy_prev = 1'b0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Wired-AND open-drain lines with pull-ups.
    assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
    assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;

    always @(negedge clk) begin
        if (bus.done) done_n <= done_n + 1;
        if (bus.error) err_n <= err_n + 1;
        if (bus.done && bus.error) both_n <= both_n + 1;
        if ((bus.done || bus.error) && (bus.busy || !busy_prev)) sync_bad <= sync_bad + 1;
        busy_prev <= bus.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits the device should see after falling edges 1..10: data LSB-first, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = ((ones % 2) == 0);
        return {1'b1, par, d};
    endfunction

    // Start a transfer and check the inhibit/request window; returns at the clock-release cycle.
    task automatic start_and_window(input logic [7:0] d, input string tag);
        int idx;
        int dat_at;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        chk({tag, "_clkoe_rise"}, 32'(bus.ps2_clk_oe), 32'd1);
        idx    = 0;
        dat_at = -1;
        while (bus.ps2_clk_oe === 1'b1 && idx < 1000) begin
            if (bus.ps2_dat_oe === 1'b1 && dat_at < 0) dat_at = idx;
            idx++;
            @(negedge clk);
        end
        chk({tag, "_clkoe_width"}, 32'(idx), 32'(INH + REQ));
        chk({tag, "_datoe_offset"}, 32'(dat_at), 32'(INH));
        chk({tag, "_start_bit"}, 32'(bus.ps2_dat_in), 32'd0);
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, input int abort_at, input bit inject,
                        input string tag);
        logic [9:0] got;
        int d0;
        int e0;
        int idx;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        got     = '0;
        d0      = done_n;
        e0      = err_n;
        start_and_window(d, tag);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == abort_at) begin
                repeat (5) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                chk({tag, "_rst_oe"}, {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'd0);
                chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
                reset   = 1'b0;
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
                chk({tag, "_rst_no_done"}, 32'(done_n - d0), 32'd0);
                chk({tag, "_rst_no_err"}, 32'(err_n - e0), 32'd0);
                return;
            end
            if (inject && k == 3) begin
                @(negedge clk);
                bus.tx_data  = 8'hAA;
                bus.tx_start = 1'b1;
                @(negedge clk);
                bus.tx_start = 1'b0;
                repeat (HALF - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = bus.ps2_dat_in;
            if (k == 10 && ack) dev_dat = 1'b0;
            if (k == 11) dev_dat = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        idx = 0;
        while (bus.busy === 1'b1 && idx < 100) begin
            idx++;
            @(negedge clk);
        end
        @(negedge clk);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, "_bits"}, 32'(got), 32'(frame_bits(d)));
        chk({tag, "_done"}, 32'(done_n - d0), ack ? 32'd1 : 32'd0);
        chk({tag, "_error"}, 32'(err_n - e0), ack ? 32'd0 : 32'd1);
        chk({tag, "_oe_idle"}, {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'd0);
    endtask

    task automatic timeout_case();
        int n;
        int e0;
        int d0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        e0      = err_n;
        d0      = done_n;
        start_and_window(8'h55, "tmo");
        n = 0;
        while (bus.error !== 1'b1 && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TMO));
        chk("tmo_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'd0);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("tmo_err_cnt", 32'(err_n - e0), 32'd1);
        chk("tmo_no_done", 32'(done_n - d0), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        dev_clk      = 1'b1;
        dev_dat      = 1'b1;
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done_err", {30'd0, bus.done, bus.error}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        xfer(8'hED, 1'b1, 0, 1'b0, "ed");
        xfer(8'hF4, 1'b1, 0, 1'b0, "f4");
        xfer(8'h00, 1'b0, 0, 1'b0, "nack00");
        timeout_case();
        xfer(8'h96, 1'b1, 4, 1'b0, "abort");
        xfer(8'hF4, 1'b1, 0, 1'b0, "f4_after_rst");
        xfer(8'h5B, 1'b1, 0, 1'b1, "inject");
        for (int r = 0; r < 4; r++) begin
            xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), 0, 1'b0, "rand");
        end

        chk("pulse_exclusive", 32'(both_n), 32'd0);
        chk("pulse_with_busy_fall", 32'(sync_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xF4 (enable), over the same PS2_CLK/PS2_DAT pair the keyboard receive path listens on. The block runs on the 50 MHz system clock, performs the clock-inhibit / request-to-send sequence, and shifts out data, odd parity and stop on device-generated clock edges. It then checks the device ACK bit. The top level converts the two open-drain enables into tri-state pad drivers, and uses `busy` to blank the receive path.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000: cycles the host holds PS2_CLK low before the request (120 µs at 50 MHz).
- REQ_CYCLES, 100: cycles with both lines held low before clock release (2 µs).
- TIMEOUT_CYCLES, 750000: cycle budget from clock release to the end of the ACK phase (15 ms).

Ports:
- clk  in  1  system clock (CLOCK_50). One clock domain.
- reset  in  1  synchronous, active-high.
- tx_data  in  8  byte to send; sampled when the start is accepted.
- tx_start  in  1  start request; accepted only when `busy`=0.
- ps2_clk_in  in  1  raw PS2_CLK pad level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release.
- busy  out  1  high from the cycle after acceptance until the return to IDLE.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: missing ACK or timeout.

## Operation
- ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
- A falling edge is "sync level was 1 on the previous cycle, is 0 now".
- States: IDLE, INHIBIT, REQ, DATA, ACK, RELEASE.
- IDLE:
  - Both oe = 0.
  - On tx_start: latch tx_data, compute parity = ~^tx_data, go to INHIBIT.
- INHIBIT: clk_oe = 1, dat_oe = 0 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ:
  - clk_oe = 1, dat_oe = 1 (start bit 0) for REQ_CYCLES cycles.
  - Then clk_oe = 0, clear bit index, start the timeout counter, go to DATA.
- DATA (dat_oe stays 1 until the first falling edge):
  - On falling edges 1–8: dat_oe = ~tx_data[k], k = 0..7 (LSB first).
  - On falling edge 9: dat_oe = ~parity.
  - On falling edge 10: dat_oe = 0 (stop bit, line released); go to ACK.
- ACK:
  - On the next falling edge, sample the synchronized data line.
  - Data = 0: ACK good, go to RELEASE.
  - Data = 1: pulse error, go to IDLE.
- RELEASE: wait until both synchronized lines are 1, then pulse done and go to IDLE.
- Timeout:
  - The counter runs in DATA, ACK and RELEASE.
  - When it reaches TIMEOUT_CYCLES-1: both oe = 0, pulse error, go to IDLE.
  - Timeout takes priority over a falling edge in the same cycle.
- tx_start while busy is ignored; there is no queueing.
- Counter widths are $clog2(parameter+1). Bit index is 4 bits.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_dat_oe = 0, busy = 0, done = 0, error = 0, state = IDLE, all counters 0.
- Reset asserted mid-transfer releases both lines on the next clk edge. No done or error is produced.
- tx_start at edge N: busy = 1 and clk_oe = 1 from N+1.
- clk_oe high time: exactly INHIBIT_CYCLES + REQ_CYCLES cycles.
- dat_oe rises REQ_CYCLES cycles before clk_oe falls.
- Data-line update latency: 3 clk cycles after the pad falling edge (2 sync + 1 register). This is well inside the ≥5 µs low phase of the device clock.
- done and error:
  - Each is exactly one cycle wide and asserted in the same cycle busy falls.
  - They are mutually exclusive.
- A new tx_start is accepted on the cycle after done or error.
- Pad glitches shorter than 1 clk cycle may be missed. No extra filtering is required.

## Test plan
- tx_data = 0xED, device model clocks at 12.5 kHz and ACKs:
  - Device samples 0,1,0,1,1,0,1,1,1 (parity 1), stop 1.
  - done pulses once; error stays 0.
- tx_data = 0xF4:
  - Bits 0,0,1,0,1,1,1,1, parity 0.
  - clk_oe high for exactly 6100 cycles, with dat_oe rising at cycle 6000 of that window.
- tx_data = 0x00, device leaves data high on the 11th clock: parity bit 1, error pulses, done stays 0, lines released.
- Device never clocks after the request: error pulses 750000 cycles after clock release, both oe = 0, busy falls.
- reset asserted after the 4th falling edge: next cycle oe = 00, busy = 0.
  - A new tx_start of 0xF4 then completes normally.
- tx_start pulsed again during DATA with tx_data = 0xAA: ignored; the original byte's bits continue unchanged.
